// File: rtl/flag_pkg.sv
// Flag controller shared definitions: W_RF codes, condition codes,
// branch FSM states and the mask helper functions.
package flag_pkg;

    localparam int NCOND = 16;
    localparam int CW    = $clog2(NCOND);

    localparam logic [2:0] WRF_NONE = 3'b000;
    localparam logic [2:0] WRF_Z    = 3'b001;
    localparam logic [2:0] WRF_SZ   = 3'b010;
    localparam logic [2:0] WRF_SCZ  = 3'b011;
    localparam logic [2:0] WRF_ALL  = 3'b100;

    localparam logic [CW-1:0] COND_AL = 4'd0;
    localparam logic [CW-1:0] COND_EQ = 4'd1;
    localparam logic [CW-1:0] COND_NE = 4'd2;
    localparam logic [CW-1:0] COND_MI = 4'd3;
    localparam logic [CW-1:0] COND_PL = 4'd4;
    localparam logic [CW-1:0] COND_CS = 4'd5;
    localparam logic [CW-1:0] COND_CC = 4'd6;
    localparam logic [CW-1:0] COND_VS = 4'd7;
    localparam logic [CW-1:0] COND_VC = 4'd8;
    localparam logic [CW-1:0] COND_LT = 4'd9;
    localparam logic [CW-1:0] COND_GE = 4'd10;
    localparam logic [CW-1:0] COND_LE = 4'd11;
    localparam logic [CW-1:0] COND_GT = 4'd12;
    localparam logic [CW-1:0] COND_HI = 4'd13;
    localparam logic [CW-1:0] COND_LS = 4'd14;
    localparam logic [CW-1:0] COND_NV = 4'd15;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_WAIT,
        BR_ACK
    } br_state_t;

    // Flags written by a W_RF code, as {O,S,C,Z}.
    function automatic logic [3:0] wrf_mask(input logic [2:0] wrf);
        case (wrf)
            WRF_Z:   return 4'b0001;
            WRF_SZ:  return 4'b0101;
            WRF_SCZ: return 4'b0111;
            WRF_ALL: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Flags read by a condition code, as {O,S,C,Z}.
    function automatic logic [3:0] need_mask(input logic [CW-1:0] cond);
        case (cond)
            COND_EQ, COND_NE: return 4'b0001;
            COND_MI, COND_PL: return 4'b0100;
            COND_CS, COND_CC: return 4'b0010;
            COND_VS, COND_VC: return 4'b1000;
            COND_LT, COND_GE: return 4'b1100;
            COND_LE, COND_GT: return 4'b1101;
            COND_HI, COND_LS: return 4'b0011;
            default:          return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/flag_ctrl_if.sv
// Flag controller bus: execute updates, branch handshake, save/restore.
// master = execute/branch/interrupt side, slave = flag_ctrl.
interface flag_ctrl_if;
    import flag_pkg::*;

    logic          ex_valid;
    logic [2:0]    ex_wrf;
    logic [3:0]    ex_flags;
    logic          br_req;
    logic [CW-1:0] br_cond;
    logic          br_ack;
    logic          br_taken;
    logic          save;
    logic          restore;
    logic [3:0]    flags;
    logic          pend;

    modport master (
        output ex_valid, ex_wrf, ex_flags,
        output br_req, br_cond, save, restore,
        input  br_ack, br_taken, flags, pend
    );

    modport slave (
        input  ex_valid, ex_wrf, ex_flags,
        input  br_req, br_cond, save, restore,
        output br_ack, br_taken, flags, pend
    );

endinterface

// File: rtl/flag_cond_eval.sv
// Combinational condition evaluator: {i_cond, i_flags} -> o_taken.
// Ports: i_cond condition code, i_flags {O,S,C,Z}, o_taken result.
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [CW-1:0] i_cond,
    input  logic [3:0]    i_flags,
    output logic          o_taken
);

    logic w_o, w_s, w_c, w_z, w_lt;

    assign w_o  = i_flags[3];
    assign w_s  = i_flags[2];
    assign w_c  = i_flags[1];
    assign w_z  = i_flags[0];
    assign w_lt = w_s ^ w_o;

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_AL: o_taken = 1'b1;
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = ~w_z;
            COND_MI: o_taken = w_s;
            COND_PL: o_taken = ~w_s;
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = ~w_c;
            COND_VS: o_taken = w_o;
            COND_VC: o_taken = ~w_o;
            COND_LT: o_taken = w_lt;
            COND_GE: o_taken = ~w_lt;
            COND_LE: o_taken = w_z | w_lt;
            COND_GT: o_taken = ~w_z & ~w_lt;
            COND_HI: o_taken = w_c & ~w_z;
            COND_LS: o_taken = ~w_c | w_z;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_ctrl.sv
// Status flag owner: pending update stage, committed flags, shadow copy,
// branch-condition FSM. Ports: clk, rst (sync, active-high), bus (slave).
module flag_ctrl
    import flag_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    flag_ctrl_if.slave  bus
);

    logic [3:0] r_flags;
    logic [3:0] r_shadow;
    logic       r_pend;
    logic [3:0] r_pmask;
    logic [3:0] r_pvals;
    logic       r_ack;
    logic       r_taken;
    br_state_t  r_state;

    logic [3:0] w_exmask;
    logic       w_cap;
    logic [3:0] w_commit;
    logic [3:0] w_need;
    logic       w_hazard;
    logic       w_eval;

    assign w_exmask = bus.ex_valid ? wrf_mask(bus.ex_wrf) : 4'b0000;
    assign w_cap    = |w_exmask;

    // Flags value after this cycle's commit, before any restore.
    assign w_commit = r_pend ? ((r_flags & ~r_pmask) | (r_pvals & r_pmask))
                             : r_flags;

    assign w_need   = need_mask(bus.br_cond);
    assign w_hazard = (r_pend & |(r_pmask & w_need)) |
                      (|(w_exmask & w_need));

    flag_cond_eval u_eval (
        .i_cond  (bus.br_cond),
        .i_flags (r_flags),
        .o_taken (w_eval)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags  <= 4'b0000;
            r_shadow <= 4'b0000;
            r_pend   <= 1'b0;
            r_pmask  <= 4'b0000;
            r_pvals  <= 4'b0000;
        end else begin
            if (bus.save)
                r_shadow <= w_commit;
            r_flags <= bus.restore ? r_shadow : w_commit;
            // Restore throws away both the pending and the incoming update.
            r_pend  <= w_cap & ~bus.restore;
            if (w_cap) begin
                r_pmask <= w_exmask;
                r_pvals <= bus.ex_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BR_IDLE;
            r_ack   <= 1'b0;
            r_taken <= 1'b0;
        end else begin
            case (r_state)
                BR_IDLE: begin
                    r_ack   <= 1'b0;
                    r_taken <= 1'b0;
                    if (bus.br_req)
                        r_state <= BR_WAIT;
                end
                BR_WAIT: begin
                    if (!bus.br_req) begin
                        r_state <= BR_IDLE;
                    end else if (!bus.restore && !w_hazard) begin
                        // Restore cycle re-evaluates on restored flags next.
                        r_ack   <= 1'b1;
                        r_taken <= w_eval;
                        r_state <= BR_ACK;
                    end
                end
                BR_ACK: begin
                    r_ack   <= 1'b0;
                    r_taken <= 1'b0;
                    r_state <= BR_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_taken <= 1'b0;
                    r_state <= BR_IDLE;
                end
            endcase
        end
    end

    assign bus.flags    = r_flags;
    assign bus.pend     = r_pend;
    assign bus.br_ack   = r_ack;
    assign bus.br_taken = r_taken;

endmodule

// File: tb/tb_flag_ctrl.sv
// Self-checking bench for flag_ctrl: directed steps, random update
// traffic against a flag model, and a full condition sweep.
module tb_flag_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] m_flags, m_shadow, m_pm, m_pv;
    logic       m_pend;
    logic [3:0] maskt [8] = '{4'h0, 4'h1, 4'h5, 4'h7,
                              4'hF, 4'h0, 4'h0, 4'h0};

    flag_ctrl_if bus ();

    flag_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input int c, input logic [3:0] f);
        bit o  = f[3];
        bit s  = f[2];
        bit cy = f[1];
        bit z  = f[0];
        bit lt = (s != o);
        bit t [16];
        t = '{1'b1, z, !z, s, !s, cy, !cy, o, !o, lt, !lt,
              z || lt, !z && !lt, cy && !z, !cy || z, 1'b0};
        return t[c];
    endfunction

    // One clock: model the edge from pre-edge inputs, then check.
    task automatic tick();
        logic [3:0] m, post, oldsh;
        m     = bus.ex_valid ? maskt[bus.ex_wrf] : 4'h0;
        post  = m_pend ? ((m_flags & ~m_pm) | (m_pv & m_pm)) : m_flags;
        oldsh = m_shadow;
        @(posedge clk);
        if (rst) begin
            m_flags = 0; m_shadow = 0; m_pend = 0; m_pm = 0; m_pv = 0;
        end else begin
            if (bus.save) m_shadow = post;
            m_flags = bus.restore ? oldsh : post;
            m_pend  = (m != 0) && !bus.restore;
            if (m != 0) begin
                m_pm = m;
                m_pv = bus.ex_flags;
            end
        end
        #1;
        chk("flags", bus.flags, m_flags);
        chk("pend", bus.pend, m_pend);
    endtask

    task automatic upd(input logic [2:0] w, input logic [3:0] f);
        bus.ex_valid = 1; bus.ex_wrf = w; bus.ex_flags = f;
        tick();
        bus.ex_valid = 0;
        tick();
    endtask

    // Tick until ack or budget; ex_valid is dropped after first cycle.
    task automatic br_wait(output int lat);
        lat = 0;
        do begin
            tick();
            bus.ex_valid = 0;
            lat++;
        end while (!bus.br_ack && lat < 20);
    endtask

    initial begin
        int lat;
        m_flags = 0; m_shadow = 0; m_pend = 0; m_pm = 0; m_pv = 0;
        rst = 1;
        bus.ex_valid = 0; bus.ex_wrf = 0; bus.ex_flags = 0;
        bus.br_req = 0; bus.br_cond = 0;
        bus.save = 0; bus.restore = 0;
        @(negedge clk);
        tick();
        chk("rst_flags", bus.flags, 0);
        chk("rst_pend", bus.pend, 0);
        chk("rst_ack", bus.br_ack, 0);
        rst = 0;

        bus.ex_valid = 1; bus.ex_wrf = 3'b100; bus.ex_flags = 4'b1010;
        tick();
        chk("upd_pend", bus.pend, 1);
        bus.ex_valid = 0;
        tick();
        chk("upd_all", bus.flags, 4'b1010);
        upd(3'b001, 4'b0001);
        chk("upd_z", bus.flags, 4'b1011);

        bus.ex_valid = 1; bus.ex_wrf = 3'b110; bus.ex_flags = 4'b1111;
        tick();
        chk("inv_pend", bus.pend, 0);
        bus.ex_valid = 0;
        tick();
        chk("inv_flags", bus.flags, 4'b1011);

        upd(3'b001, 4'b0000);
        bus.ex_valid = 1; bus.ex_wrf = 3'b001; bus.ex_flags = 4'b0001;
        bus.br_req = 1; bus.br_cond = 4'd1;
        br_wait(lat);
        chk("haz_lat", lat, 3);
        chk("haz_taken", bus.br_taken, 1);
        bus.br_req = 0;
        tick();
        chk("haz_ackdrop", bus.br_ack, 0);

        bus.ex_valid = 1; bus.ex_wrf = 3'b001; bus.ex_flags = 4'b0000;
        bus.br_req = 1; bus.br_cond = 4'd5;
        br_wait(lat);
        chk("nohaz_lat", lat, 2);
        chk("nohaz_taken", bus.br_taken, 1);
        bus.br_req = 0;
        tick();

        upd(3'b100, 4'b0110);
        bus.save = 1;
        tick();
        bus.save = 0;
        upd(3'b100, 4'b1111);
        chk("sr_upd", bus.flags, 4'b1111);
        bus.restore = 1;
        bus.ex_valid = 1; bus.ex_wrf = 3'b100; bus.ex_flags = 4'b0001;
        tick();
        bus.restore = 0; bus.ex_valid = 0;
        chk("sr_flags", bus.flags, 4'b0110);
        chk("sr_pend", bus.pend, 0);
        tick();
        chk("sr_hold", bus.flags, 4'b0110);

        for (int i = 0; i < 300; i++) begin
            bus.ex_valid = 1'($urandom_range(0, 1));
            bus.ex_wrf   = 3'($urandom_range(0, 7));
            bus.ex_flags = 4'($urandom);
            bus.save     = ($urandom_range(0, 7) == 0);
            bus.restore  = ($urandom_range(0, 7) == 0);
            tick();
        end
        bus.ex_valid = 0; bus.save = 0; bus.restore = 0;
        tick();

        for (int v = 0; v < 16; v++) begin
            upd(3'b100, 4'(v));
            for (int c = 0; c < 16; c++) begin
                bus.br_req = 1; bus.br_cond = 4'(c);
                br_wait(lat);
                chk($sformatf("cond%0d_f%0h_lat", c, v), lat, 2);
                chk($sformatf("cond%0d_f%0h", c, v),
                    bus.br_taken, ref_taken(c, 4'(v)));
                bus.br_req = 0;
                tick();
            end
        end

        bus.ex_valid = 1; bus.ex_wrf = 3'b001; bus.ex_flags = 4'b0001;
        bus.br_req = 1; bus.br_cond = 4'd2;
        tick();
        bus.ex_valid = 0;
        rst = 1;
        tick();
        chk("rstw_ack", bus.br_ack, 0);
        rst = 0; bus.br_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstw_noack", bus.br_ack, 0);
        end

        bus.ex_valid = 1; bus.ex_wrf = 3'b001; bus.ex_flags = 4'b0001;
        bus.br_req = 1; bus.br_cond = 4'd1;
        tick();
        bus.ex_valid = 0; bus.br_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_noack", bus.br_ack, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
